// File: rtl/rib_data_bridge.sv
// Registered two-master data-bus bridge (jtag m1 over core m0) onto one decoded slave bus.
// Optional ACCESS watchdog enabled by defining RIB_TIMEOUT_EN.
//   state  | meaning
//   IDLE   | arbitrate, latch the winning access
//   ACCESS | s_req_o held until s_ack_i (or watchdog expiry)
//   RESP   | one-cycle ack/data/err to the latched owner
module rib_data_bridge #(
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [31:0]           m0_addr_i,
    input  logic [31:0]           m0_data_i,
    output logic [31:0]           m0_data_o,
    output logic                  m0_ack_o,
    output logic                  hold_flag_o,
    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [31:0]           m1_addr_i,
    input  logic [31:0]           m1_data_i,
    output logic [31:0]           m1_data_o,
    output logic                  m1_ack_o,
    output logic                  s_req_o,
    output logic                  s_we_o,
    output logic [NUM_SLAVES-1:0] s_sel_o,
    output logic [31:0]           s_addr_o,
    output logic [31:0]           s_data_o,
    input  logic [31:0]           s_data_i,
    input  logic                  s_ack_i,
    output logic                  bus_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [4:0] NUM_SLAVES_W = 5'(NUM_SLAVES);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;   // 1 = jtag (m1)
    logic        we_q, we_d;
    logic [27:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [3:0]  req_idx;
    logic        req_mapped;

`ifdef RIB_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign req_idx    = m1_req_i ? m1_addr_i[31:28] : m0_addr_i[31:28];
    assign req_mapped = ({1'b0, req_idx} < NUM_SLAVES_W);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef RIB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m1_req_i || m0_req_i) begin
                    owner_d = m1_req_i;
                    we_d    = m1_req_i ? m1_we_i : m0_we_i;
                    addr_d  = m1_req_i ? m1_addr_i[27:0] : m0_addr_i[27:0];
                    wdata_d = m1_req_i ? m1_data_i : m0_data_i;
                    idx_d   = req_idx;
                    rdata_d = 32'h0;
                    err_d   = ~req_mapped;
                    state_d = req_mapped ? ST_ACCESS : ST_RESP;
`ifdef RIB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_ACCESS: begin
                // a late ack in the expiry cycle still completes normally
                if (s_ack_i) begin
                    rdata_d = we_q ? 32'h0 : s_data_i;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
`ifdef RIB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_sel_o = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_sel_o[i] = (state_q == ST_ACCESS) && (idx_q == 4'(i));
        end
    end

    assign s_req_o     = (state_q == ST_ACCESS);
    assign s_we_o      = s_req_o & we_q;
    assign s_addr_o    = s_req_o ? {4'h0, addr_q} : 32'h0;
    assign s_data_o    = s_req_o ? wdata_q : 32'h0;
    assign m0_ack_o    = (state_q == ST_RESP) & ~owner_q;
    assign m1_ack_o    = (state_q == ST_RESP) & owner_q;
    assign m0_data_o   = m0_ack_o ? rdata_q : 32'h0;
    assign m1_data_o   = m1_ack_o ? rdata_q : 32'h0;
    assign bus_err_o   = (state_q == ST_RESP) & err_q;
    assign hold_flag_o = m0_req_i & ~m0_ack_o;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 28'h0;
            wdata_q <= 32'h0;
            idx_q   <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
`ifdef RIB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef RIB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_rib_data_bridge.sv
// Directed bench for rib_data_bridge: reads, writes, arbitration, unmapped decode, stall, reset.
module tb_rib_data_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m0_we_i;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic        m0_ack_o, hold_flag_o;
    logic        m1_req_i, m1_we_i;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic        m1_ack_o;
    logic        s_req_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic        s_ack_i, bus_err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rib_data_bridge #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .hold_flag_o(hold_flag_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_addr_o(s_addr_o),
        .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i), .bus_err_o(bus_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        m0_req_i = 0; m0_we_i = 0; m0_addr_i = 0; m0_data_i = 0;
        m1_req_i = 0; m1_we_i = 0; m1_addr_i = 0; m1_data_i = 0;
        s_data_i = 0; s_ack_i = 0;
        cyc(); cyc();
        #1;
        chk("rst_s_req", 32'(s_req_o), 32'd0);
        chk("rst_s_sel", 32'(s_sel_o), 32'd0);
        chk("rst_m0_ack", 32'(m0_ack_o), 32'd0);
        chk("rst_m1_ack", 32'(m1_ack_o), 32'd0);
        chk("rst_hold", 32'(hold_flag_o), 32'd0);
        chk("rst_bus_err", 32'(bus_err_o), 32'd0);
        rst = 1'b1;
        cyc();

        // 1: m0 read, slave 1 acks in second ACCESS cycle
        m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h1000_0010;
        #1;
        chk("t1_hold_idle", 32'(hold_flag_o), 32'd1);
        chk("t1_no_req_idle", 32'(s_req_o), 32'd0);
        cyc(); #1;
        chk("t1_s_req", 32'(s_req_o), 32'd1);
        chk("t1_s_sel", 32'(s_sel_o), 32'b0010);
        chk("t1_s_addr", s_addr_o, 32'h0000_0010);
        chk("t1_s_we", 32'(s_we_o), 32'd0);
        chk("t1_hold_acc", 32'(hold_flag_o), 32'd1);
        cyc();
        s_ack_i = 1; s_data_i = 32'hA5A5_0001;
        #1;
        chk("t1_s_req_acc2", 32'(s_req_o), 32'd1);
        cyc();
        s_ack_i = 0; s_data_i = 32'h0;
        #1;
        chk("t1_m0_ack", 32'(m0_ack_o), 32'd1);
        chk("t1_m0_data", m0_data_o, 32'hA5A5_0001);
        chk("t1_hold_resp", 32'(hold_flag_o), 32'd0);
        chk("t1_bus_err", 32'(bus_err_o), 32'd0);
        chk("t1_s_req_resp", 32'(s_req_o), 32'd0);
        chk("t1_m1_ack", 32'(m1_ack_o), 32'd0);

        // 2: back-to-back m0 write, presented the cycle after RESP
        cyc();
        m0_we_i = 1; m0_addr_i = 32'h2000_0004; m0_data_i = 32'h1234_5678;
        #1;
        chk("t2_m0_ack_idle", 32'(m0_ack_o), 32'd0);
        chk("t2_m0_data_idle", m0_data_o, 32'd0);
        chk("t2_hold_idle", 32'(hold_flag_o), 32'd1);
        cyc();
        s_ack_i = 1; s_data_i = 32'hDEAD_BEEF;
        #1;
        chk("t2_s_req", 32'(s_req_o), 32'd1);
        chk("t2_s_we", 32'(s_we_o), 32'd1);
        chk("t2_s_data", s_data_o, 32'h1234_5678);
        chk("t2_s_sel", 32'(s_sel_o), 32'b0100);
        chk("t2_s_addr", s_addr_o, 32'h0000_0004);
        cyc();
        s_ack_i = 0; s_data_i = 32'h0;
        #1;
        chk("t2_m0_ack", 32'(m0_ack_o), 32'd1);
        chk("t2_m0_data_wr", m0_data_o, 32'd0);
        chk("t2_bus_err", 32'(bus_err_o), 32'd0);
        cyc();
        m0_req_i = 0; m0_we_i = 0; m0_data_i = 0;
        #1;
        chk("t2_hold_drop", 32'(hold_flag_o), 32'd0);

        // 3: simultaneous requests, m1 wins first
        m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h0000_0008;
        m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h3000_000C;
        cyc();
        s_ack_i = 1; s_data_i = 32'hBEEF_0003;
        #1;
        chk("t3_m1_sel", 32'(s_sel_o), 32'b1000);
        chk("t3_m1_addr", s_addr_o, 32'h0000_000C);
        chk("t3_hold_m1", 32'(hold_flag_o), 32'd1);
        cyc();
        s_ack_i = 0; s_data_i = 32'h0;
        #1;
        chk("t3_m1_ack", 32'(m1_ack_o), 32'd1);
        chk("t3_m1_data", m1_data_o, 32'hBEEF_0003);
        chk("t3_m0_ack_n", 32'(m0_ack_o), 32'd0);
        chk("t3_m0_data_n", m0_data_o, 32'd0);
        chk("t3_hold_m1resp", 32'(hold_flag_o), 32'd1);
        cyc();
        m1_req_i = 0;
        #1;
        chk("t3_hold_idle2", 32'(hold_flag_o), 32'd1);
        cyc();
        s_ack_i = 1; s_data_i = 32'h0000_CAFE;
        #1;
        chk("t3_m0_sel", 32'(s_sel_o), 32'b0001);
        chk("t3_m0_addr", s_addr_o, 32'h0000_0008);
        cyc();
        s_ack_i = 0; s_data_i = 32'h0;
        #1;
        chk("t3_m0_ack", 32'(m0_ack_o), 32'd1);
        chk("t3_m0_data", m0_data_o, 32'h0000_CAFE);
        chk("t3_hold_m0resp", 32'(hold_flag_o), 32'd0);
        chk("t3_m1_ack_n", 32'(m1_ack_o), 32'd0);
        cyc();
        m0_req_i = 0;

        // 4: unmapped targets complete with error and never reach the slave bus
        m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h5000_0000;
        cyc(); #1;
        chk("t4_no_s_req", 32'(s_req_o), 32'd0);
        chk("t4_m0_ack", 32'(m0_ack_o), 32'd1);
        chk("t4_m0_data", m0_data_o, 32'd0);
        chk("t4_bus_err", 32'(bus_err_o), 32'd1);
        cyc();
        m0_we_i = 1; m0_addr_i = 32'h4000_0000; m0_data_i = 32'h1111_2222;
        cyc(); #1;
        chk("t4_idx4_no_req", 32'(s_req_o), 32'd0);
        chk("t4_idx4_err", 32'(bus_err_o), 32'd1);
        cyc();
        m0_req_i = 0; m0_we_i = 0; m0_data_i = 0;
        #1;
        chk("t4_err_pulse", 32'(bus_err_o), 32'd0);

        // 5: slave never acks
        m0_req_i = 1; m0_addr_i = 32'h0000_0040;
`ifdef RIB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            cyc(); #1;
            chk("t5_req_held", 32'(s_req_o), 32'd1);
            chk("t5_no_ack", 32'(m0_ack_o), 32'd0);
        end
        cyc(); #1;
        chk("t5_to_s_req", 32'(s_req_o), 32'd0);
        chk("t5_to_ack", 32'(m0_ack_o), 32'd1);
        chk("t5_to_err", 32'(bus_err_o), 32'd1);
        chk("t5_to_data", m0_data_o, 32'd0);
        cyc();
        m0_req_i = 0;
`else
        for (int i = 0; i < 40; i++) begin
            cyc(); #1;
            chk("t5_req_held", 32'(s_req_o), 32'd1);
            chk("t5_hold_held", 32'(hold_flag_o), 32'd1);
            chk("t5_no_ack", 32'(m0_ack_o), 32'd0);
        end
        rst = 1'b0;
        cyc();
        rst = 1'b1; m0_req_i = 0;
        #1;
        chk("t5_recover", 32'(s_req_o), 32'd0);
`endif
        cyc();

        // 6: reset in the second ACCESS cycle abandons the access
        m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h1000_0000;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("t6_req_before", 32'(s_req_o), 32'd1);
        cyc();
        rst = 1'b1;
        #1;
        chk("t6_s_req", 32'(s_req_o), 32'd0);
        chk("t6_hold", 32'(hold_flag_o), 32'd1);
        chk("t6_no_ack", 32'(m0_ack_o), 32'd0);
        cyc(); #1;
        chk("t6_idle_accepts", 32'(s_req_o), 32'd1);
        chk("t6_sel", 32'(s_sel_o), 32'b0010);
        s_ack_i = 1; s_data_i = 32'h0000_0777;
        cyc();
        s_ack_i = 0; s_data_i = 0;
        #1;
        chk("t6_m0_data", m0_data_o, 32'h0000_0777);
        cyc();
        m0_req_i = 0;
        #1;
        chk("t6_hold_follow", 32'(hold_flag_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
